vx_mem_tag_remap: RTL

- Sits directly downstream of the cluster's memory port (L2 or memory-arbiter output), between the cluster and the external memory interface.
- Replaces each wide outgoing read tag with a compact slot index, bounds the number of outstanding reads, and restores the original tag on the response.
- Lets the memory controller see a narrow, fixed tag space independent of cluster configuration.

---
 rtl/vx_mem_tag_pkg.sv | 9 +
 rtl/vx_mem_tag_remap_chk.sv | 13 +
 rtl/vx_tag_slot_alloc.sv | 55 +++++
 rtl/vx_mem_tag_remap.sv | 133 +++++++++++++
 4 files changed

// File: rtl/vx_mem_tag_pkg.sv
// Shared types and constants for the memory tag remapper.
package vx_mem_tag_pkg;

    localparam int DEFAULT_NUM_SLOTS = 16;
    localparam int PERF_CNT_W        = 44;

    typedef logic [$clog2(DEFAULT_NUM_SLOTS)-1:0] slot_idx_t;

endpackage

// File: rtl/vx_mem_tag_remap_chk.sv
// Protocol checker: a response handshake must name a slot that is outstanding.
module vx_mem_tag_remap_chk (
    input logic clk,
    input logic reset,
    input logic rsp_fire,
    input logic rsp_slot_busy
);

    a_rsp_to_busy_slot: assert property (@(posedge clk) disable iff (reset)
        rsp_fire |-> rsp_slot_busy)
        else $error("memory response to a slot with no outstanding read");

endmodule

// File: rtl/vx_tag_slot_alloc.sv
// Outstanding-read slot tracker: busy mask, lowest-free allocation, free on response.
module vx_tag_slot_alloc
    import vx_mem_tag_pkg::*;
#(
    parameter int  NUM_SLOTS = DEFAULT_NUM_SLOTS,
    localparam int SLOT_W    = $clog2(NUM_SLOTS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 alloc_en,
    input  logic                 free_en,
    input  logic [SLOT_W-1:0]    free_idx,
    output logic [SLOT_W-1:0]    alloc_idx,
    output logic [NUM_SLOTS-1:0] busy_mask,
    output logic                 full,
    output logic                 busy
);

    logic                 found_s;
    logic [NUM_SLOTS-1:0] alloc_onehot_s;
    logic [NUM_SLOTS-1:0] free_onehot_s;

    // Priority encoder: lowest-index free slot.
    always_comb begin
        alloc_idx = '0;
        found_s   = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!busy_mask[i] && !found_s) begin
                alloc_idx = SLOT_W'(i);
                found_s   = 1'b1;
            end else begin
                found_s   = found_s;
            end
        end
    end

    // One-hot set/clear vectors; alloc and free never target the same slot.
    always_comb begin
        alloc_onehot_s = alloc_en ? (NUM_SLOTS'(1) << alloc_idx) : '0;
        free_onehot_s  = free_en  ? (NUM_SLOTS'(1) << free_idx)  : '0;
    end

    // Busy mask register.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_mask <= '0;
        end else begin
            busy_mask <= (busy_mask | alloc_onehot_s) & ~free_onehot_s;
        end
    end

    assign full = &busy_mask;
    assign busy = |busy_mask;

endmodule

// File: rtl/vx_mem_tag_remap.sv
// Swaps wide cluster read tags for compact slot indices and restores them on response.
// Optional VX_MEM_TAG_REMAP_PERF_EN adds read, stall and peak-occupancy counters.
module vx_mem_tag_remap
    import vx_mem_tag_pkg::*;
#(
    parameter int  NUM_SLOTS     = DEFAULT_NUM_SLOTS,
    parameter int  DATA_WIDTH    = 512,
    parameter int  ADDR_WIDTH    = 26,
    parameter int  TAG_IN_WIDTH  = 12,
    parameter int  TAG_OUT_WIDTH = $clog2(NUM_SLOTS),
    localparam int SLOT_W        = $clog2(NUM_SLOTS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid_in,
    input  logic                      req_rw_in,
    input  logic [DATA_WIDTH/8-1:0]   req_byteen_in,
    input  logic [ADDR_WIDTH-1:0]     req_addr_in,
    input  logic [DATA_WIDTH-1:0]     req_data_in,
    input  logic [TAG_IN_WIDTH-1:0]   req_tag_in,
    output logic                      req_ready_in,
    output logic                      mem_req_valid,
    output logic                      mem_req_rw,
    output logic [DATA_WIDTH/8-1:0]   mem_req_byteen,
    output logic [ADDR_WIDTH-1:0]     mem_req_addr,
    output logic [DATA_WIDTH-1:0]     mem_req_data,
    output logic [TAG_OUT_WIDTH-1:0]  mem_req_tag,
    input  logic                      mem_req_ready,
    input  logic                      mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]     mem_rsp_data,
    input  logic [TAG_OUT_WIDTH-1:0]  mem_rsp_tag,
    output logic                      mem_rsp_ready,
    output logic                      rsp_valid_out,
    output logic [DATA_WIDTH-1:0]     rsp_data_out,
    output logic [TAG_IN_WIDTH-1:0]   rsp_tag_out,
    input  logic                      rsp_ready_out,
    output logic                      busy
`ifdef VX_MEM_TAG_REMAP_PERF_EN
    ,
    output logic [PERF_CNT_W-1:0]     perf_reads,
    output logic [PERF_CNT_W-1:0]     perf_stall_cycles,
    output logic [SLOT_W:0]           perf_peak_outstanding
`endif
);

    logic [SLOT_W-1:0]       alloc_idx_s;
    logic [SLOT_W-1:0]       rsp_slot_s;
    logic [NUM_SLOTS-1:0]    busy_mask_s;
    logic                    full_s;
    logic                    can_issue_s;
    logic                    alloc_fire_s;
    logic                    rsp_fire_s;
    logic [TAG_IN_WIDTH-1:0] tag_table_r [NUM_SLOTS];

    // Writes bypass the slot limit; reads need a free slot.
    assign can_issue_s    = req_rw_in | ~full_s;
    assign mem_req_valid  = req_valid_in & can_issue_s;
    assign req_ready_in   = mem_req_ready & can_issue_s;
    assign mem_req_rw     = req_rw_in;
    assign mem_req_byteen = req_byteen_in;
    assign mem_req_addr   = req_addr_in;
    assign mem_req_data   = req_data_in;
    assign mem_req_tag    = req_rw_in ? '0 : TAG_OUT_WIDTH'(alloc_idx_s);

    assign alloc_fire_s   = mem_req_valid & mem_req_ready & ~req_rw_in;
    assign rsp_slot_s     = mem_rsp_tag[SLOT_W-1:0];
    assign rsp_fire_s     = mem_rsp_valid & rsp_ready_out;

    assign rsp_valid_out  = mem_rsp_valid;
    assign rsp_data_out   = mem_rsp_data;
    assign rsp_tag_out    = tag_table_r[rsp_slot_s];
    assign mem_rsp_ready  = rsp_ready_out;

    vx_tag_slot_alloc #(
        .NUM_SLOTS (NUM_SLOTS)
    ) u_alloc (
        .clk       (clk),
        .reset     (reset),
        .alloc_en  (alloc_fire_s),
        .free_en   (rsp_fire_s),
        .free_idx  (rsp_slot_s),
        .alloc_idx (alloc_idx_s),
        .busy_mask (busy_mask_s),
        .full      (full_s),
        .busy      (busy)
    );

    // Tag table: contents are meaningful only where the busy mask is set.
    always_ff @(posedge clk) begin
        if (alloc_fire_s) begin
            tag_table_r[alloc_idx_s] <= req_tag_in;
        end
    end

    vx_mem_tag_remap_chk u_chk (
        .clk           (clk),
        .reset         (reset),
        .rsp_fire      (rsp_fire_s),
        .rsp_slot_busy (busy_mask_s[rsp_slot_s])
    );

`ifdef VX_MEM_TAG_REMAP_PERF_EN
    logic [SLOT_W:0] occupancy_s;

    // Current number of outstanding slots.
    always_comb begin
        occupancy_s = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            occupancy_s = occupancy_s + {{SLOT_W{1'b0}}, busy_mask_s[i]};
        end
    end

    // Performance counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_reads            <= '0;
            perf_stall_cycles     <= '0;
            perf_peak_outstanding <= '0;
        end else begin
            if (alloc_fire_s) begin
                perf_reads <= perf_reads + PERF_CNT_W'(1);
            end
            if (req_valid_in && !req_rw_in && full_s) begin
                perf_stall_cycles <= perf_stall_cycles + PERF_CNT_W'(1);
            end
            if (occupancy_s > perf_peak_outstanding) begin
                perf_peak_outstanding <= occupancy_s;
            end
        end
    end
`endif

endmodule
